uart_cmd_frame_parser: RTL and testbench

Sequences the byte stream from the UART receiver into fixed-format coprocessor commands. It hunts for a start-of-frame byte, collects an opcode and two 32-bit operands, and verifies an XOR checksum. A valid command is presented on a valid/ready handshake to the coprocessor core, and malformed, stalled or overrun frames are reported and discarded. It sits between the UART receiver's `o_rx_done`/`o_rx_byte` outputs and the command dispatch logic.

---
 rtl/uart_cmd_frame_parser_if.sv | 26 ++
 rtl/uart_cmd_frame_parser.sv | 135 +++++++++++++
 tb/tb_uart_cmd_frame_parser.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_frame_parser_if.sv
// Bundles the byte stream from the UART receiver, the command handshake and
// the status outputs of uart_cmd_frame_parser.
//   slave  : parser side (consumes rx bytes and cmd_ready, drives command/status)
//   master : environment side (UART receiver + command consumer)
interface uart_cmd_frame_parser_if;
  logic        i_rx_done;
  logic [7:0]  i_rx_byte;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [7:0]  o_opcode;
  logic [31:0] o_op_a;
  logic [31:0] o_op_b;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [7:0]  o_frame_cnt;

  modport slave (
    input  i_rx_done, i_rx_byte, i_cmd_ready,
    output o_cmd_valid, o_opcode, o_op_a, o_op_b, o_err, o_err_code, o_frame_cnt
  );

  modport master (
    output i_rx_done, i_rx_byte, i_cmd_ready,
    input  o_cmd_valid, o_opcode, o_op_a, o_op_b, o_err, o_err_code, o_frame_cnt
  );
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// Turns the UART receiver byte stream into coprocessor commands.
// Frame: SOF, OPCODE, A3..A0, B3..B0, CSUM (CSUM = XOR of OPCODE..B0).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : i_rx_done/i_rx_byte byte input (rising edge of done = 1 byte),
//                    o_cmd_valid/i_cmd_ready command handshake with opcode and
//                    big-endian operands, o_err pulse + o_err_code
//                    (01 checksum, 10 timeout, 11 overrun), o_frame_cnt.
module uart_cmd_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 4340,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  uart_cmd_frame_parser_if.slave bus
);
  localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  GAP_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_OPA, S_OPB, S_CSUM, S_HOLD} state_e;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [7:0]    xor_q;
  logic [CW-1:0] gap_q;
  logic          r_done_d_q;
  logic          valid_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [7:0]    opcode_q;
  logic [7:0]    cnt_q;
  logic [31:0]   op_a_q;
  logic [31:0]   op_b_q;

  logic       acc;
  logic       xfer;
  logic       counting;
  logic [7:0] rx_b;

  // A long rx_done level counts once: only its rising edge accepts a byte.
  assign acc      = bus.i_rx_done & ~r_done_d_q;
  assign xfer     = valid_q & bus.i_cmd_ready;
  assign rx_b     = bus.i_rx_byte;
  assign counting = (state_q == S_OPC) || (state_q == S_OPA) ||
                    (state_q == S_OPB) || (state_q == S_CSUM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      xor_q      <= 8'd0;
      gap_q      <= '0;
      r_done_d_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      opcode_q   <= 8'd0;
      cnt_q      <= 8'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
    end else begin
      r_done_d_q <= bus.i_rx_done;
      err_q      <= 1'b0;

      // Gap counter: an accepted byte always wins over expiry.
      if (acc || !counting)      gap_q <= '0;
      else if (gap_q != GAP_MAX) gap_q <= gap_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          xor_q <= 8'd0;
          if (acc && rx_b == SOF_BYTE) state_q <= S_OPC;
        end
        S_OPC: if (acc) begin
          opcode_q <= rx_b;
          xor_q    <= xor_q ^ rx_b;
          idx_q    <= 2'd0;
          state_q  <= S_OPA;
        end
        S_OPA: if (acc) begin
          op_a_q <= {op_a_q[23:0], rx_b};
          xor_q  <= xor_q ^ rx_b;
          idx_q  <= idx_q + 2'd1;  // wraps to 0 for the next operand
          if (idx_q == 2'd3) state_q <= S_OPB;
        end
        S_OPB: if (acc) begin
          op_b_q <= {op_b_q[23:0], rx_b};
          xor_q  <= xor_q ^ rx_b;
          idx_q  <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= S_CSUM;
        end
        S_CSUM: if (acc) begin
          if (rx_b == xor_q) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
            state_q    <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (xfer) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
            xor_q   <= 8'd0;
            // A byte landing on the handshake cycle is treated as an IDLE byte.
            state_q <= (acc && rx_b == SOF_BYTE) ? S_OPC : S_IDLE;
          end else if (acc) begin
            // Held command is untouched; the new byte is simply lost.
            err_q      <= 1'b1;
            err_code_q <= 2'b11;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Timeout overrides the (byte-less) case above.
      if (counting && !acc && gap_q == GAP_MAX) begin
        err_q      <= 1'b1;
        err_code_q <= 2'b10;
        state_q    <= S_IDLE;
        gap_q      <= '0;
      end
    end
  end

  assign bus.o_cmd_valid = valid_q;
  assign bus.o_opcode    = opcode_q;
  assign bus.o_op_a      = op_a_q;
  assign bus.o_op_b      = op_b_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = err_code_q;
  assign bus.o_frame_cnt = cnt_q;
endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
module tb_uart_cmd_frame_parser;
  localparam int unsigned TO = 4340;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_frame_parser_if bus();

  uart_cmd_frame_parser #(.TIMEOUT_CYCLES(TO), .SOF_BYTE(8'hA5)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Event monitor, sampled on the falling edge.
  int          err_cnt  = 0;
  int          xfer_cnt = 0;
  logic [7:0]  cap_opc  = 8'h00;
  logic [31:0] cap_a    = 32'h0;
  logic [31:0] cap_b    = 32'h0;
  always @(negedge clk) begin
    if (bus.o_err) err_cnt++;
    if (bus.o_cmd_valid && bus.i_cmd_ready) begin
      xfer_cnt++;
      cap_opc = bus.o_opcode;
      cap_a   = bus.o_op_a;
      cap_b   = bus.o_op_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at posedge+1. One accepted byte per call.
  task automatic send_byte(input logic [7:0] b, input int hi);
    bus.i_rx_byte = b;
    bus.i_rx_done = 1'b1;
    repeat (hi) @(posedge clk);
    #1 bus.i_rx_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] cs, input int hi);
    logic [7:0] f [11];
    f[0] = 8'hA5; f[1] = opc;
    f[2] = a[31:24]; f[3] = a[23:16]; f[4] = a[15:8]; f[5] = a[7:0];
    f[6] = b[31:24]; f[7] = b[23:16]; f[8] = b[15:8]; f[9] = b[7:0];
    f[10] = cs;
    for (int i = 0; i < 11; i++) send_byte(f[i], hi);
  endtask

  function automatic logic [7:0] csum(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
    return opc ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction

  initial begin
    int e0, x0;
    logic [31:0] wa;
    rst_n = 1'b0;
    bus.i_rx_done = 1'b0; bus.i_rx_byte = 8'h00; bus.i_cmd_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", bus.o_cmd_valid, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_code", bus.o_err_code, 0);
    chk("rst_opc", bus.o_opcode, 0);
    chk("rst_a", bus.o_op_a, 0);
    chk("rst_b", bus.o_op_b, 0);
    chk("rst_cnt", bus.o_frame_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid frame, ready high. XOR of 01 12 34 56 78 9A BC DE F0 is 0x01.
    bus.i_cmd_ready = 1'b1;
    send_byte(8'hA5, 1); send_byte(8'h01, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h56, 1); send_byte(8'h78, 1);
    send_byte(8'h9A, 1); send_byte(8'hBC, 1); send_byte(8'hDE, 1); send_byte(8'hF0, 1);
    bus.i_rx_byte = 8'h01; bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    chk("lat_valid", bus.o_cmd_valid, 1);
    chk("v_opc", bus.o_opcode, 8'h01);
    chk("v_a", bus.o_op_a, 32'h12345678);
    chk("v_b", bus.o_op_b, 32'h9ABCDEF0);
    bus.i_rx_done = 1'b0;
    @(posedge clk); #1;
    chk("v_valid_drop", bus.o_cmd_valid, 0);
    chk("v_cnt", bus.o_frame_cnt, 1);
    chk("v_noerr", err_cnt, 0);

    // Bad checksum, then a good frame
    e0 = err_cnt; x0 = xfer_cnt;
    send_frame(8'h01, 32'h12345678, 32'h9ABCDEF0, 8'h00, 1);
    @(posedge clk); #1;
    chk("cs_errs", err_cnt - e0, 1);
    chk("cs_code", bus.o_err_code, 2'b01);
    chk("cs_noxfer", xfer_cnt - x0, 0);
    chk("cs_valid", bus.o_cmd_valid, 0);
    send_frame(8'h01, 32'h12345678, 32'h9ABCDEF0, 8'h01, 1);
    @(posedge clk); #1;
    chk("cs_recover_cnt", bus.o_frame_cnt, 2);

    // Garbage in IDLE is silent
    e0 = err_cnt;
    send_byte(8'h3C, 1); send_byte(8'h00, 1); send_byte(8'hFF, 1);
    repeat (5) @(posedge clk); #1;
    chk("garbage_noerr", err_cnt - e0, 0);

    // Timeout after a partial frame
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h12, 1);
    repeat (TO - 20) @(posedge clk); #1;
    chk("to_early", err_cnt - e0, 0);
    for (int i = 0; i < 60 && err_cnt == e0; i++) @(posedge clk);
    #1;
    chk("to_err", err_cnt - e0, 1);
    chk("to_code", bus.o_err_code, 2'b10);
    send_frame(8'h01, 32'h12345678, 32'h9ABCDEF0, 8'h01, 1);
    @(posedge clk); #1;
    chk("to_idle_cnt", bus.o_frame_cnt, 3);

    // Overrun: held command, three extra bytes. XOR of 5A DEADBEEF 01020304 = 0x7C.
    bus.i_cmd_ready = 1'b0;
    e0 = err_cnt;
    send_frame(8'h5A, 32'hDEADBEEF, 32'h01020304, 8'h7C, 1);
    chk("ov_valid", bus.o_cmd_valid, 1);
    send_byte(8'hA5, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    chk("ov_errs", err_cnt - e0, 3);
    chk("ov_code", bus.o_err_code, 2'b11);
    chk("ov_hold_valid", bus.o_cmd_valid, 1);
    chk("ov_opc", bus.o_opcode, 8'h5A);
    chk("ov_a", bus.o_op_a, 32'hDEADBEEF);
    chk("ov_b", bus.o_op_b, 32'h01020304);
    bus.i_cmd_ready = 1'b1;
    @(posedge clk); #1;
    chk("ov_xfer_valid", bus.o_cmd_valid, 0);
    chk("ov_cnt", bus.o_frame_cnt, 4);
    chk("ov_cap_a", cap_a, 32'hDEADBEEF);

    // Long rx_done levels. XOR of 33 11223344 55667788 = 0xBB.
    e0 = err_cnt; x0 = xfer_cnt;
    send_frame(8'h33, 32'h11223344, 32'h55667788, 8'hBB, 500);
    chk("lvl_xfer", xfer_cnt - x0, 1);
    chk("lvl_cnt", bus.o_frame_cnt, 5);
    chk("lvl_opc", cap_opc, 8'h33);
    chk("lvl_a", cap_a, 32'h11223344);
    chk("lvl_b", cap_b, 32'h55667788);
    chk("lvl_noerr", err_cnt - e0, 0);

    // Reset after byte 6
    x0 = xfer_cnt;
    send_byte(8'hA5, 1); send_byte(8'h77, 1);
    send_byte(8'hCA, 1); send_byte(8'hFE, 1); send_byte(8'hF0, 1); send_byte(8'h0D, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_opc", bus.o_opcode, 0);
    chk("mrst_a", bus.o_op_a, 0);
    chk("mrst_cnt", bus.o_frame_cnt, 0);
    chk("mrst_valid", bus.o_cmd_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h0B, 1); send_byte(8'hAD, 1); send_byte(8'hBE, 1); send_byte(8'hEF, 1);
    send_byte(8'h00, 1);
    repeat (3) @(posedge clk); #1;
    chk("mrst_nocmd", xfer_cnt - x0, 0);
    chk("mrst_valid2", bus.o_cmd_valid, 0);

    // Frame counter wrap over 256 frames
    x0 = xfer_cnt;
    for (int i = 0; i < 256; i++) begin
      wa = 32'(i) * 32'h01010101;
      send_frame(8'(i), wa, ~wa, csum(8'(i), wa, ~wa), 1);
      if (i == 254) chk("wrap_255", bus.o_frame_cnt, 255);
    end
    chk("wrap_0", bus.o_frame_cnt, 0);
    chk("wrap_xfers", xfer_cnt - x0, 256);
    chk("wrap_last_b", cap_b, 32'h00000000);

    // SOF edge on the handshake cycle. XOR: 42^01^02 = 0x41; 24 10203040 50607080 = 0xA4.
    e0 = err_cnt; x0 = xfer_cnt;
    bus.i_cmd_ready = 1'b0;
    send_frame(8'h42, 32'h00000001, 32'h00000002, 8'h41, 1);
    repeat (3) @(posedge clk); #1;
    bus.i_cmd_ready = 1'b1;
    bus.i_rx_byte = 8'hA5; bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
    chk("hs_cap_opc", cap_opc, 8'h42);
    @(posedge clk); #1;
    send_byte(8'h24, 1);
    send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h30, 1); send_byte(8'h40, 1);
    send_byte(8'h50, 1); send_byte(8'h60, 1); send_byte(8'h70, 1); send_byte(8'h80, 1);
    send_byte(8'hA4, 1);
    chk("hs_noovr", err_cnt - e0, 0);
    chk("hs_xfers", xfer_cnt - x0, 2);
    chk("hs_opc", cap_opc, 8'h24);
    chk("hs_a", cap_a, 32'h10203040);
    chk("hs_b", cap_b, 32'h50607080);
    chk("hs_cnt", bus.o_frame_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
